// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDR SDRAM command encodings, error codes and mode fields.
// Used by the device responder and by controller-side benches.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_MODE       = 3'b000,
    CMD_REFRESH    = 3'b001,
    CMD_PRECHARGE  = 3'b010,
    CMD_ACTIVATE   = 3'b011,
    CMD_WRITE      = 3'b100,
    CMD_READ       = 3'b101,
    CMD_BURST_STOP = 3'b110,
    CMD_NOP        = 3'b111
  } cmd_e;

  typedef enum logic [3:0] {
    ERR_NONE     = 4'd0,
    ERR_INIT     = 4'd1,
    ERR_MODE     = 4'd2,
    ERR_ACT_OPEN = 4'd3,
    ERR_CLOSED   = 4'd4,
    ERR_TRCD     = 4'd5,
    ERR_BUS      = 4'd6,
    ERR_REF_OPEN = 4'd7,
    ERR_REF_LATE = 4'd8
  } err_e;

  typedef enum logic [1:0] {
    ST_POWERUP,
    ST_PRECHARGED,
    ST_REFRESHING,
    ST_READY
  } init_e;

  localparam int MODE_CL_LSB = 4;
  localparam int MODE_BL_LSB = 0;
  localparam int A10         = 10;

  function automatic logic [15:0] lane_mask(
    input logic [15:0] d,
    input logic [1:0]  m
  );
    return {m[1] ? 8'h00 : d[15:8],
            m[0] ? 8'h00 : d[7:0]};
  endfunction

endpackage

// File: rtl/sdram_device_responder_if.sv
// sdram_device_responder_if: SDR SDRAM pin bundle between controller and device.
// master = controller side, slave = device side.
interface sdram_device_responder_if;
  logic [12:0] sdram_a;
  logic [1:0]  sdram_bs;
  logic        sdram_cs_n;
  logic        sdram_ras_n;
  logic        sdram_cas_n;
  logic        sdram_we_n;
  logic [1:0]  sdram_dqm;
  logic        sdram_cke;
  logic [15:0] sdram_dout;
  logic        sdram_dout_en;
  logic [15:0] sdram_din;

  modport master (
    output sdram_a, sdram_bs, sdram_cs_n,
    output sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_dqm, sdram_cke,
    output sdram_dout, sdram_dout_en,
    input  sdram_din
  );

  modport slave (
    input  sdram_a, sdram_bs, sdram_cs_n,
    input  sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_dqm, sdram_cke,
    input  sdram_dout, sdram_dout_en,
    output sdram_din
  );
endinterface

// File: rtl/sdram_model_mem.sv
// sdram_model_mem: 1R1W byte-enabled backing RAM with registered read.
// Contents are never reset.
module sdram_model_mem #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);
  logic [7:0] lo [0:(1<<AW)-1];
  logic [7:0] hi [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we && be[0]) lo[waddr] <= wdata[7:0];
    if (we && be[1]) hi[waddr] <= wdata[15:8];
    if (re) rdata <= {hi[raddr], lo[raddr]};
  end
endmodule

// File: rtl/sdram_device_responder.sv
// sdram_device_responder: SDR SDRAM device model for the controller pin bus.
// Decodes commands, tracks init and banks, returns CL-delayed reads, flags errors.
module sdram_device_responder
  import sdram_pkg::*;
#(
  parameter int MEM_AW       = 12,
  parameter int COL_DEPTH    = 10,
  parameter int ROW_DEPTH    = 13,
  parameter int INIT_REFRESH = 8,
  parameter int TRCD         = 2,
  parameter int REFRESH_MAX  = 512
) (
  input  logic clk,
  input  logic rst,
  sdram_device_responder_if.slave bus,
  output logic init_done,
  output logic err,
  output err_e err_code
);
  localparam int IRW = $clog2(INIT_REFRESH + 1);
  localparam int TW  = $clog2(TRCD + 1);
  localparam int RCW = $clog2(REFRESH_MAX + 2);
  localparam int FAW = 2 + ROW_DEPTH + COL_DEPTH;

  init_e st, st_nx;
  logic [IRW-1:0] ref_n, ref_n_nx;
  cmd_e cmd;
  logic [1:0] bs;
  logic a10, sel;
  logic is_mode, is_ref, is_pre;
  logic is_act, is_wr, is_rd;
  logic mode_wr, act_ok, rd_ok, wr_ok;
  logic pre_ok, ap, ref_hit, bad_mode;
  err_e e;

  logic [3:0] bank_open;
  logic [ROW_DEPTH-1:0] row_q [4];
  logic [TW-1:0] trcd_q [4];
  logic [2:0] mode_cl;
  logic [RCW-1:0] ref_cnt;

  logic v1, v2, rd_cl2, din_upd;
  logic [1:0] m1, m2;
  logic [15:0] d2, rdata;
  logic [FAW-1:0] full_addr;
  logic [MEM_AW-1:0] mem_addr;
  logic unused_addr;

  assign sel = !bus.sdram_cs_n && bus.sdram_cke;
  assign cmd = sel ? cmd_e'({bus.sdram_ras_n,
                             bus.sdram_cas_n,
                             bus.sdram_we_n})
                   : CMD_NOP;
  assign bs  = bus.sdram_bs;
  assign a10 = bus.sdram_a[A10];

  assign is_mode = cmd == CMD_MODE;
  assign is_ref  = cmd == CMD_REFRESH;
  assign is_pre  = cmd == CMD_PRECHARGE;
  assign is_act  = cmd == CMD_ACTIVATE;
  assign is_wr   = cmd == CMD_WRITE;
  assign is_rd   = cmd == CMD_READ;

  assign bad_mode =
    (bus.sdram_a[MODE_CL_LSB+:3] != 3'd2 &&
     bus.sdram_a[MODE_CL_LSB+:3] != 3'd3) ||
    bus.sdram_a[MODE_BL_LSB+:3] != 3'd0;

  assign rd_cl2  = v1 && (mode_cl != 3'd3);
  assign din_upd = rd_cl2 || v2;
  assign init_done = (st == ST_READY);

  always_comb begin
    st_nx    = st;
    ref_n_nx = ref_n;
    e        = ERR_NONE;
    mode_wr  = 1'b0;
    act_ok   = 1'b0;
    rd_ok    = 1'b0;
    wr_ok    = 1'b0;
    pre_ok   = 1'b0;
    ap       = 1'b0;
    ref_hit  = 1'b0;
    unique case (st)
      ST_POWERUP: begin
        if (is_pre && a10) st_nx = ST_PRECHARGED;
        else if (cmd != CMD_NOP) e = ERR_INIT;
      end
      ST_PRECHARGED: begin
        if (is_mode) begin
          st_nx    = ST_REFRESHING;
          ref_n_nx = '0;
          mode_wr  = 1'b1;
        end else if (cmd != CMD_NOP) e = ERR_INIT;
      end
      ST_REFRESHING: begin
        if (is_ref) begin
          ref_n_nx = ref_n + 1'b1;
          if (ref_n == IRW'(INIT_REFRESH - 1))
            st_nx = ST_READY;
        end else if (cmd != CMD_NOP) e = ERR_INIT;
      end
      ST_READY: begin
        unique case (1'b1)
          is_mode: begin
            if (|bank_open) e = ERR_INIT;
            else mode_wr = 1'b1;
          end
          is_ref: begin
            ref_hit = 1'b1;
            if (|bank_open) e = ERR_REF_OPEN;
          end
          is_pre: pre_ok = 1'b1;
          is_act: begin
            if (bank_open[bs]) e = ERR_ACT_OPEN;
            else act_ok = 1'b1;
          end
          is_rd, is_wr: begin
            if (!bank_open[bs]) e = ERR_CLOSED;
            else begin
              ap = a10;
              if (trcd_q[bs] != '0) e = ERR_TRCD;
              else begin
                rd_ok = is_rd;
                wr_ok = is_wr;
                if (is_wr && !bus.sdram_dout_en)
                  e = ERR_BUS;
              end
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    if (e == ERR_NONE && mode_wr && bad_mode)
      e = ERR_MODE;
    if (e == ERR_NONE && din_upd && bus.sdram_dout_en)
      e = ERR_BUS;
    if (e == ERR_NONE && st == ST_READY &&
        ref_cnt > RCW'(REFRESH_MAX))
      e = ERR_REF_LATE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= ST_POWERUP;
      ref_n <= '0;
    end else begin
      st    <= st_nx;
      ref_n <= ref_n_nx;
    end
  end

  // {bank,row,col} folded into the RAM; upper bits alias by design
  assign full_addr = {bs, row_q[bs],
                      bus.sdram_a[COL_DEPTH-1:0]};
  assign mem_addr = full_addr[MEM_AW-1:0];
  assign unused_addr = ^full_addr[FAW-1:MEM_AW];

  sdram_model_mem #(.AW(MEM_AW)) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .be    (~bus.sdram_dqm & {2{bus.sdram_dout_en}}),
    .waddr (mem_addr),
    .wdata (bus.sdram_dout),
    .re    (rd_ok),
    .raddr (mem_addr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_open <= '0;
      for (int b = 0; b < 4; b++) begin
        row_q[b]  <= '0;
        trcd_q[b] <= '0;
      end
      mode_cl  <= '0;
      ref_cnt  <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      m1       <= '0;
      m2       <= '0;
      d2       <= '0;
      bus.sdram_din <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      if (mode_wr)
        mode_cl <= bus.sdram_a[MODE_CL_LSB+:3];
      for (int b = 0; b < 4; b++) begin
        if (act_ok && bs == 2'(b))
          trcd_q[b] <= TW'(TRCD - 1);
        else if (trcd_q[b] != '0)
          trcd_q[b] <= trcd_q[b] - 1'b1;
      end
      if (act_ok) begin
        bank_open[bs] <= 1'b1;
        row_q[bs]     <= bus.sdram_a[ROW_DEPTH-1:0];
      end
      if (pre_ok && a10) bank_open <= '0;
      else if (pre_ok || ap) bank_open[bs] <= 1'b0;
      if (st != ST_READY || ref_hit) ref_cnt <= '0;
      else if (ref_cnt != '1) ref_cnt <= ref_cnt + 1'b1;
      // mem read is stage one; CL3 adds one more register
      v1 <= rd_ok;
      m1 <= bus.sdram_dqm;
      v2 <= v1 && (mode_cl == 3'd3);
      d2 <= rdata;
      m2 <= bus.sdram_dqm;
      if (rd_cl2)
        bus.sdram_din <= lane_mask(rdata, m1);
      else if (v2)
        bus.sdram_din <= lane_mask(d2, m2);
      if (!err && e != ERR_NONE) begin
        err      <= 1'b1;
        err_code <= e;
      end
    end
  end
endmodule

// File: tb/tb_sdram_device_responder.sv
// tb_sdram_device_responder: scoreboard bench for the SDRAM device responder.
// Expected read words come from a bench-side word model keyed like the device RAM.
module tb_sdram_device_responder;
  import sdram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_done, err;
  err_e err_code;
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp, last_exp;
  logic [15:0] model [logic [11:0]];
  logic [12:0] brow [4];

  sdram_device_responder_if bus();

  sdram_device_responder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .init_done (init_done),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] maddr(
    input logic [1:0] b, input logic [12:0] r,
    input logic [9:0] c);
    logic [24:0] f;
    f = {b, r, c};
    return f[11:0];
  endfunction

  function automatic logic [15:0] lmask(
    input logic [15:0] v, input logic [1:0] m);
    return {m[1] ? 8'h00 : v[15:8], m[0] ? 8'h00 : v[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input cmd_e c, input logic [1:0] b,
    input logic [12:0] a, input logic [1:0] m,
    input logic [15:0] d, input logic den);
    @(negedge clk);
    bus.sdram_cs_n = 1'b0;
    {bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = c;
    bus.sdram_bs = b;
    bus.sdram_a = a;
    bus.sdram_dqm = m;
    bus.sdram_dout = d;
    bus.sdram_dout_en = den;
    tick();
    bus.sdram_cs_n = 1'b1;
    bus.sdram_dqm = 2'b00;
    bus.sdram_dout_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_init();
    issue(CMD_PRECHARGE, 2'd0, 13'h400, 2'b00, 16'h0, 1'b0);
    issue(CMD_MODE, 2'd0, 13'h020, 2'b00, 16'h0, 1'b0);
    repeat (8) issue(CMD_REFRESH, 2'd0, 13'h0, 2'b00, 16'h0, 1'b0);
  endtask

  task automatic act(input logic [1:0] b, input logic [12:0] r);
    issue(CMD_ACTIVATE, b, r, 2'b00, 16'h0, 1'b0);
    brow[b] = r;
  endtask

  task automatic wr(input logic [1:0] b, input logic [9:0] c,
    input logic [15:0] d, input logic [1:0] m, input logic apc);
    logic [11:0] k;
    logic [15:0] old;
    k = maddr(b, brow[b], c);
    old = model.exists(k) ? model[k] : 16'h0;
    model[k] = {m[1] ? old[15:8] : d[15:8], m[0] ? old[7:0] : d[7:0]};
    issue(CMD_WRITE, b, {2'b00, apc, c}, m, d, 1'b1);
  endtask

  task automatic rd(input logic [1:0] b, input logic [9:0] c,
    input logic [1:0] m);
    exp_q.push_back(lmask(model[maddr(b, brow[b], c)], m));
    issue(CMD_READ, b, {3'b000, c}, m, 16'h0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (bus.sdram_din !== 16'h0) begin
      failures++; $display("FAIL rst_din got=%h want=0000", bus.sdram_din);
    end
    checks++;
    if (init_done !== 1'b0) begin
      failures++; $display("FAIL rst_init_done got=%b want=0", init_done);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL rst_err got=%b want=0", err);
    end
    checks++;
    if (err_code !== ERR_NONE) begin
      failures++; $display("FAIL rst_code got=%0d want=0", err_code);
    end
    do_reset();
  endtask

  task automatic test_init();
    issue(CMD_PRECHARGE, 2'd0, 13'h400, 2'b00, 16'h0, 1'b0);
    issue(CMD_MODE, 2'd0, 13'h020, 2'b00, 16'h0, 1'b0);
    repeat (7) issue(CMD_REFRESH, 2'd0, 13'h0, 2'b00, 16'h0, 1'b0);
    checks++;
    if (init_done !== 1'b0) begin
      failures++; $display("FAIL init_7ref got=%b want=0", init_done);
    end
    issue(CMD_REFRESH, 2'd0, 13'h0, 2'b00, 16'h0, 1'b0);
    checks++;
    if (init_done !== 1'b1) begin
      failures++; $display("FAIL init_8ref got=%b want=1", init_done);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL init_err got=%b want=0", err);
    end
  endtask

  task automatic test_write_read();
    act(2'd1, 13'd5);
    nop(1);
    wr(2'd1, 10'd3, 16'hBEEF, 2'b00, 1'b1);
    act(2'd1, 13'd5);
    nop(1);
    rd(2'd1, 10'd3, 2'b00);
    nop(1);
    exp = exp_q.pop_front();
    last_exp = exp;
    checks++;
    if (bus.sdram_din !== exp) begin
      failures++; $display("FAIL wr_rd got=%h want=%h", bus.sdram_din, exp);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL wr_rd_err got=%b want=0", err);
    end
  endtask

  task automatic test_byte_mask();
    wr(2'd1, 10'd7, 16'h1234, 2'b00, 1'b0);
    wr(2'd1, 10'd7, 16'hABCD, 2'b01, 1'b0);
    rd(2'd1, 10'd7, 2'b00);
    nop(1);
    exp = exp_q.pop_front();
    last_exp = exp;
    checks++;
    if (bus.sdram_din !== exp) begin
      failures++; $display("FAIL wmask got=%h want=%h", bus.sdram_din, exp);
    end
    rd(2'd1, 10'd7, 2'b10);
    nop(1);
    exp = exp_q.pop_front();
    last_exp = exp;
    checks++;
    if (bus.sdram_din !== exp) begin
      failures++; $display("FAIL rmask got=%h want=%h", bus.sdram_din, exp);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      wr(2'd1, 10'(16 + i), 16'(i * 16'h1111) ^ 16'h5A5A, 2'b00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rd(2'd1, 10'(16 + i), 2'b00);
      if (i > 0) begin
        exp = exp_q.pop_front();
        last_exp = exp;
        checks++;
        if (bus.sdram_din !== exp) begin
          failures++;
          $display("FAIL b2b_%0d got=%h want=%h", i - 1, bus.sdram_din, exp);
        end
      end
    end
    nop(1);
    exp = exp_q.pop_front();
    last_exp = exp;
    checks++;
    if (bus.sdram_din !== exp) begin
      failures++; $display("FAIL b2b_5 got=%h want=%h", bus.sdram_din, exp);
    end
  endtask

  task automatic test_cl3();
    issue(CMD_PRECHARGE, 2'd0, 13'h400, 2'b00, 16'h0, 1'b0);
    issue(CMD_REFRESH, 2'd0, 13'h0, 2'b00, 16'h0, 1'b0);
    issue(CMD_MODE, 2'd0, 13'h030, 2'b00, 16'h0, 1'b0);
    act(2'd2, 13'd9);
    nop(1);
    wr(2'd2, 10'd1, 16'hC3C3, 2'b00, 1'b0);
    exp_q.push_back(lmask(model[maddr(2'd2, brow[2], 10'd1)], 2'b01));
    issue(CMD_READ, 2'd2, 13'd1, 2'b00, 16'h0, 1'b0);
    @(negedge clk);
    bus.sdram_dqm = 2'b01;
    tick();
    bus.sdram_dqm = 2'b00;
    checks++;
    if (bus.sdram_din !== last_exp) begin
      failures++; $display("FAIL cl3_early got=%h want=%h", bus.sdram_din, last_exp);
    end
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (bus.sdram_din !== exp) begin
      failures++; $display("FAIL cl3_data got=%h want=%h", bus.sdram_din, exp);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL cl3_err got=%b want=0", err);
    end
  endtask

  task automatic test_closed();
    do_reset();
    do_init();
    issue(CMD_READ, 2'd2, 13'd0, 2'b00, 16'h0, 1'b0);
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL closed_err got=%b want=1", err);
    end
    checks++;
    if (err_code !== ERR_CLOSED) begin
      failures++; $display("FAIL closed_code got=%0d want=%0d", err_code, ERR_CLOSED);
    end
    act(2'd0, 13'd1);
    act(2'd0, 13'd1);
    checks++;
    if (err_code !== ERR_CLOSED) begin
      failures++; $display("FAIL closed_sticky got=%0d want=%0d", err_code, ERR_CLOSED);
    end
  endtask

  task automatic test_trcd();
    do_reset();
    do_init();
    act(2'd0, 13'd1);
    issue(CMD_READ, 2'd0, 13'd0, 2'b00, 16'h0, 1'b0);
    checks++;
    if (err_code !== ERR_TRCD) begin
      failures++; $display("FAIL trcd got=%0d want=%0d", err_code, ERR_TRCD);
    end
  endtask

  task automatic test_bus_err();
    do_reset();
    do_init();
    act(2'd3, 13'd2);
    nop(1);
    issue(CMD_WRITE, 2'd3, 13'd4, 2'b00, 16'h7777, 1'b0);
    checks++;
    if (err_code !== ERR_BUS) begin
      failures++; $display("FAIL bus got=%0d want=%0d", err_code, ERR_BUS);
    end
  endtask

  task automatic test_init_err();
    do_reset();
    act(2'd0, 13'd1);
    checks++;
    if (err_code !== ERR_INIT) begin
      failures++; $display("FAIL init_err got=%0d want=%0d", err_code, ERR_INIT);
    end
    checks++;
    if (init_done !== 1'b0) begin
      failures++; $display("FAIL init_err_done got=%b want=0", init_done);
    end
  endtask

  task automatic test_mode_err();
    do_reset();
    issue(CMD_PRECHARGE, 2'd0, 13'h400, 2'b00, 16'h0, 1'b0);
    issue(CMD_MODE, 2'd0, 13'h040, 2'b00, 16'h0, 1'b0);
    checks++;
    if (err_code !== ERR_MODE) begin
      failures++; $display("FAIL mode got=%0d want=%0d", err_code, ERR_MODE);
    end
  endtask

  task automatic test_ref_late();
    int n;
    do_reset();
    do_init();
    nop(505);
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL ref_early got=%b want=0", err);
    end
    n = 0;
    while (!err && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 9) begin
      failures++; $display("FAIL ref_late_cycles got=%0d want=9", n);
    end
    checks++;
    if (err_code !== ERR_REF_LATE) begin
      failures++; $display("FAIL ref_late_code got=%0d want=%0d", err_code, ERR_REF_LATE);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    do_init();
    act(2'd1, 13'd5);
    nop(1);
    rd(2'd1, 10'd3, 2'b00);
    nop(1);
    exp = exp_q.pop_front();
    checks++;
    if (bus.sdram_din !== exp) begin
      failures++; $display("FAIL mid_pre got=%h want=%h", bus.sdram_din, exp);
    end
    rd(2'd1, 10'd7, 2'b00);
    exp_q.delete();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.sdram_din !== 16'h0) begin
      failures++; $display("FAIL mid_rst_din got=%h want=0000", bus.sdram_din);
    end
    checks++;
    if (init_done !== 1'b0) begin
      failures++; $display("FAIL mid_rst_done got=%b want=0", init_done);
    end
    @(negedge clk);
    rst = 1'b0;
    nop(3);
    checks++;
    if (bus.sdram_din !== 16'h0) begin
      failures++; $display("FAIL mid_rst_late got=%h want=0000", bus.sdram_din);
    end
  endtask

  initial begin
    bus.sdram_a = '0;
    bus.sdram_bs = '0;
    bus.sdram_cs_n = 1'b1;
    bus.sdram_ras_n = 1'b1;
    bus.sdram_cas_n = 1'b1;
    bus.sdram_we_n = 1'b1;
    bus.sdram_dqm = 2'b00;
    bus.sdram_cke = 1'b1;
    bus.sdram_dout = '0;
    bus.sdram_dout_en = 1'b0;
    last_exp = 16'h0;
    for (int b = 0; b < 4; b++) brow[b] = '0;
    test_reset();
    test_init();
    test_write_read();
    test_byte_mask();
    test_back_to_back();
    test_cl3();
    test_closed();
    test_trcd();
    test_bus_err();
    test_init_err();
    test_mode_err();
    test_ref_late();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
